dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory serving one request at a time; DMEM_OOR_EN adds err_o range checking.
// Latency: ready_o pulses exactly Latency cycles after the accepting IDLE cycle, then one GAP cycle.
// Backpressure: none; a request is only taken while IDLE (busy_o low), later input changes are ignored.
module dmem_responder #(
  parameter int DWidth  = 32,
  parameter int Depth   = 1024,
  parameter int Latency = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic [DWidth-1:0] rdata_o,
  output logic              ready_o,
`ifdef DMEM_OOR_EN
  output logic              busy_o,
  output logic              err_o
`else
  output logic              busy_o
`endif
);

  localparam int AW = $clog2(Depth);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [AW-1:0]     idx_q;
  logic [DWidth-1:0] wdata_q;
  logic              oor_q;
  logic              oor_d;
  logic              resp_wr;
  logic [AW-1:0]     resp_idx;
  logic              resp_oor;
  logic              enter_resp;
  logic [DWidth-1:0] mem [Depth];

`ifdef DMEM_OOR_EN
  logic unused_addr;
  assign oor_d       = |addr_i[DWidth-1:AW+2];
  assign unused_addr = ^addr_i[1:0];
`else
  // Upper address bits alias into the array when range checking is off.
  logic unused_addr;
  assign oor_d       = 1'b0;
  assign unused_addr = ^{addr_i[DWidth-1:AW+2], addr_i[1:0]};
`endif

  assign busy_o = (state != IDLE);

  // With Latency=1 the response is formed straight from the accepting inputs.
  always_comb begin
    resp_wr  = wr_q;
    resp_idx = idx_q;
    resp_oor = oor_q;
    if (state == IDLE) begin
      resp_wr  = write_i;
      resp_idx = addr_i[AW+1:2];
      resp_oor = oor_d;
    end
  end

  assign enter_resp = (Latency == 1) ? (state == IDLE && req_i)
                                     : (state == WAIT && cnt == 4'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      ready_o <= 1'b0;
      rdata_o <= '0;
`ifdef DMEM_OOR_EN
      err_o   <= 1'b0;
`endif
    end else begin
      ready_o <= 1'b0;
      rdata_o <= '0;
`ifdef DMEM_OOR_EN
      err_o   <= 1'b0;
`endif
      if (enter_resp) begin
        ready_o <= 1'b1;
        rdata_o <= (!resp_wr && !resp_oor) ? mem[resp_idx] : '0;
`ifdef DMEM_OOR_EN
        err_o   <= resp_oor;
`endif
      end
      case (state)
        IDLE: begin
          if (req_i) begin
            wr_q    <= write_i;
            idx_q   <= addr_i[AW+1:2];
            wdata_q <= wdata_i;
            oor_q   <= oor_d;
            if (Latency == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(Latency - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A reset during the transaction leaves state IDLE, so the pending write never lands.
  always_ff @(posedge clk_i) begin
    if (state == RESP && wr_q && !oor_q) mem[idx_q] <= wdata_q;
  end

endmodule
